multdiv_seq_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It is the successor to the fixed 32-bit latched-operand multdiv wrapper.
- Captures operands, destination tag and op type on a start pulse.
- Runs a one-bit-per-cycle signed shift-add multiply or restoring divide.
- Returns the result with tag and exception, plus a busy signal for pipeline stall logic.
- Adds width parametrisation, busy/accept handshake, flush, early divide-by-zero completion and back-to-back issue.

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_iter_core.sv | 108 ++++++++++
 rtl/multdiv_seq_unit.sv | 90 +++++++++
 tb/tb_multdiv_seq_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encodings, operation enum, signed-minimum helper.
package multdiv_pkg;

  // FSM state encodings (kept as plain constants for legacy tooling).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [1:0] state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Most negative two's-complement value for a given width (width <= 64).
  function automatic logic [63:0] signed_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Iterative datapath: one shift-add (multiply) or restoring (divide) step per cycle on magnitudes.
// Latency: WIDTH steps after load; result/exception register on the step flagged last.
// Backpressure: none; load/step/last are driven by the controlling FSM.
// Ports: clock, reset (sync, active-high); load captures operand_a/operand_b/op_div;
//        step advances one iteration, last also applies sign fix-up and writes result/exception.
module multdiv_iter_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

  // hi: product high half / partial remainder; lo: multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_mag_q;
  logic             neg_q;
  op_e              op_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] fix_res;
  logic             fix_exc;
  logic             unused_diff_msb;

  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
  endfunction

  // Without a borrow the remainder is below the divisor, so bit WIDTH is always 0.
  assign unused_diff_msb = div_diff[WIDTH];

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_mag_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_mag_q};
    hi_n      = hi_q;
    lo_n      = lo_q;
    if (op_q == OP_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH+1]) begin
      // trial subtract borrowed: restore (keep shifted remainder), quotient bit 0
      hi_n = div_shift[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      hi_n = div_diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end

    // Low half of the product and the quotient both end up in lo_n.
    fix_res = neg_q ? (WIDTH'(0) - lo_n) : lo_n;
    if (op_q == OP_MUL) begin
      // Fits iff magnitude < 2^(W-1), or == 2^(W-1) for a negative product.
      fix_exc = (hi_n != '0) || (lo_n[WIDTH-1] && !(neg_q && (lo_n == MIN_VAL)));
    end else begin
      // Only MIN / -1 yields a positive quotient of 2^(W-1).
      fix_exc = !neg_q && (lo_n == MIN_VAL);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      opb_mag_q <= '0;
      neg_q     <= 1'b0;
      op_q      <= OP_MUL;
      result    <= '0;
      exception <= 1'b0;
    end else if (load) begin
      hi_q      <= '0;
      lo_q      <= mag(operand_a);
      opb_mag_q <= mag(operand_b);
      neg_q     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      op_q      <= op_div ? OP_DIV : OP_MUL;
      if (op_div && (operand_b == '0)) begin
        // divide-by-zero completes immediately; no iterations follow
        result    <= '0;
        exception <= 1'b1;
      end
    end else if (step) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (last) begin
        result    <= fix_res;
        exception <= fix_exc;
      end
    end
  end

endmodule

// File: rtl/multdiv_seq_unit.sv
// Signed iterative multiply/divide unit with tag tracking for the execute stage.
// Latency: WIDTH+1 edges from accept to result_valid (1 edge for divide-by-zero).
// Backpressure: busy high while iterating; starts during busy or with flush are ignored.
// Ports: clock, reset (sync, active-high); start_mul/start_div/flush requests; operand_a/b, tag_in;
//        busy, result_valid (1-cycle pulse), result, exception, tag_out/is_mult/is_div (held since accept).
module multdiv_seq_unit
  import multdiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out,
  output logic             is_mult,
  output logic             is_div
);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             accept;
  logic             div_zero;
  logic             last_iter;

  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);

  // DONE accepts too, giving back-to-back issue; flush blocks any accept.
  assign accept    = (start_mul | start_div) && !flush && ((state == IDLE) || (state == DONE));
  // multiply wins when both starts are high
  assign div_zero  = !start_mul && start_div && (operand_b == '0);
  assign last_iter = (counter == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      tag_out <= '0;
      is_mult <= 1'b0;
      is_div  <= 1'b0;
    end else if (accept) begin
      tag_out <= tag_in;
      is_mult <= start_mul;
      is_div  <= !start_mul;
      counter <= '0;
      state   <= div_zero ? DONE : RUN;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else if (last_iter) begin
            state <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  multdiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .step      (busy && !flush),
    .last      (last_iter),
    .op_div    (!start_mul),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .exception (exception)
  );

endmodule

// File: tb/tb_multdiv_seq_unit.sv
module tb_multdiv_seq_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 32-bit instance
  logic        rst32, sm32, sd32, fl32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  tg32, tago32;
  logic        busy32, rv32, exc32, im32, id32;

  // 8-bit instance
  logic        rst8, sm8, sd8, fl8;
  logic [7:0]  a8, b8, res8;
  logic [4:0]  tg8, tago8;
  logic        busy8, rv8, exc8, im8, id8;

  multdiv_seq_unit u_dut32 (
    .clock(clock), .reset(rst32), .start_mul(sm32), .start_div(sd32), .flush(fl32),
    .operand_a(a32), .operand_b(b32), .tag_in(tg32), .busy(busy32), .result_valid(rv32),
    .result(res32), .exception(exc32), .tag_out(tago32), .is_mult(im32), .is_div(id32)
  );

  multdiv_seq_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(rst8), .start_mul(sm8), .start_div(sd8), .flush(fl8),
    .operand_a(a8), .operand_b(b8), .tag_in(tg8), .busy(busy8), .result_valid(rv8),
    .result(res8), .exception(exc8), .tag_out(tago8), .is_mult(im8), .is_div(id8)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [4:0]  tag;
    logic        mul;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: cycle counter advances on each falling edge, outputs sampled there.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (rv32) begin
      if (q32.size() == 0) begin
        chk("w32_unexpected_pulse", 64'(rv32), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("w32_latency", 64'(cyc), 64'(e.due));
        chk("w32_result", 64'(res32), 64'(e.res));
        chk("w32_exception", 64'(exc32), 64'(e.exc));
        chk("w32_tag", 64'(tago32), 64'(e.tag));
        chk("w32_is_mult", 64'(im32), 64'(e.mul));
        chk("w32_is_div", 64'(id32), 64'(!e.mul));
      end
    end else if (q32.size() > 0 && cyc > q32[0].due) begin
      chk("w32_missing_pulse", 64'(rv32), 64'd1);
      void'(q32.pop_front());
    end
    if (rv8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_pulse", 64'(rv8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("w8_latency", 64'(cyc), 64'(e.due));
        chk("w8_result", 64'(res8), 64'(e.res[7:0]));
        chk("w8_exception", 64'(exc8), 64'(e.exc));
        chk("w8_tag", 64'(tago8), 64'(e.tag));
        chk("w8_is_mult", 64'(im8), 64'(e.mul));
        chk("w8_is_div", 64'(id8), 64'(!e.mul));
      end
    end else if (q8.size() > 0 && cyc > q8[0].due) begin
      chk("w8_missing_pulse", 64'(rv8), 64'd1);
      void'(q8.pop_front());
    end
  end

  // All stimulus tasks are entered 1 time unit after a falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic issue32(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic push, input logic [31:0] er,
                         input logic ee, input int lat, output int at);
    sm32 = mul; sd32 = div; a32 = a; b32 = b; tg32 = tag;
    at = cyc;
    if (push) q32.push_back('{res: er, exc: ee, tag: tag, mul: mul, due: cyc + lat});
    wait_cyc(1);
    sm32 = 1'b0; sd32 = 1'b0;
  endtask

  task automatic issue8(input logic mul, input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] tag, input logic push, input logic [7:0] er,
                        input logic ee, input int lat);
    sm8 = mul; sd8 = !mul; a8 = a; b8 = b; tg8 = tag;
    if (push) q8.push_back('{res: {24'd0, er}, exc: ee, tag: tag, mul: mul, due: cyc + lat});
    wait_cyc(1);
    sm8 = 1'b0; sd8 = 1'b0;
  endtask

  // Independent 8-bit reference using plain integer arithmetic.
  function automatic void model8(input logic mul, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic e);
    int sa, sb, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (mul) begin
      p = sa * sb;
      r = p[7:0];
      e = (p > 127) || (p < -128);
    end else if (sb == 0) begin
      r = 8'd0;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[7:0];
      e = (p > 127);
    end
  endfunction

  initial begin
    int          i;
    int          dummy;
    logic [7:0]  ra, rb, er8;
    logic        ee8, om;
    logic [7:0]  va[7]  = '{8'h80, 8'h80, 8'h7F, 8'h80, 8'hF9, 8'h07, 8'h00};
    logic [7:0]  vb[7]  = '{8'hFF, 8'h01, 8'h7F, 8'hFF, 8'h02, 8'h00, 8'hFB};
    logic        vm[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst32 = 1'b1; sm32 = 1'b0; sd32 = 1'b0; fl32 = 1'b0; a32 = '0; b32 = '0; tg32 = '0;
    rst8  = 1'b1; sm8  = 1'b0; sd8  = 1'b0; fl8  = 1'b0; a8  = '0; b8  = '0; tg8  = '0;
    @(negedge clock); #1;
    wait_cyc(2);

    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_result_valid", 64'(rv32), 64'd0);
    chk("rst_result", 64'(res32), 64'd0);
    chk("rst_exception", 64'(exc32), 64'd0);
    chk("rst_tag_out", 64'(tago32), 64'd0);
    chk("rst_is_mult", 64'(im32), 64'd0);
    chk("rst_is_div", 64'(id32), 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;
    wait_cyc(1);

    // -7 * 6 = -42
    issue32(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd6, 5'd9, 1'b1, 32'hFFFF_FFD6, 1'b0, 33, i);
    wait_cyc(4);
    chk("mul_busy_mid", 64'(busy32), 64'd1);
    wait_cyc(32);
    // 100 / -7 = -14
    issue32(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd3, 1'b1, 32'hFFFF_FFF2, 1'b0, 33, i);
    wait_cyc(36);
    // 5 / 0: early completion
    issue32(1'b0, 1'b1, 32'd5, 32'd0, 5'd4, 1'b1, 32'd0, 1'b1, 1, i);
    wait_cyc(3);
    // 2^30 * 4 overflows to 0
    issue32(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd5, 1'b1, 32'd0, 1'b1, 33, i);
    wait_cyc(36);
    // MIN / -1
    issue32(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h8000_0000, 1'b1, 33, i);
    wait_cyc(36);
    // both starts: multiply wins
    issue32(1'b1, 1'b1, 32'd5, 32'd3, 5'd8, 1'b1, 32'd15, 1'b0, 33, i);
    wait_cyc(36);

    // flush at RUN cycle 10, then 9 / 3
    issue32(1'b1, 1'b0, 32'd123, 32'd456, 5'd10, 1'b0, 32'd0, 1'b0, 33, i);
    wait_cyc(9);
    fl32 = 1'b1;
    wait_cyc(1);
    fl32 = 1'b0;
    issue32(1'b0, 1'b1, 32'd9, 32'd3, 5'd12, 1'b1, 32'd3, 1'b0, 33, i);
    wait_cyc(36);

    // starts during RUN ignored; start in the DONE cycle accepted back-to-back
    issue32(1'b0, 1'b1, 32'd50, 32'd5, 5'd7, 1'b1, 32'd10, 1'b0, 33, i);
    goto(i + 5);
    issue32(1'b0, 1'b1, 32'd77, 32'd7, 5'd13, 1'b0, 32'd0, 1'b0, 33, dummy);
    goto(i + 20);
    issue32(1'b0, 1'b1, 32'd1000, 32'd10, 5'd14, 1'b0, 32'd0, 1'b0, 33, dummy);
    goto(i + 33);
    issue32(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 5'd2, 1'b1, 32'hFFFF_FFF4, 1'b0, 33, dummy);
    wait_cyc(36);

    // flush during DONE: pulse still seen, simultaneous start dropped
    issue32(1'b1, 1'b0, 32'd2, 32'd3, 5'd1, 1'b1, 32'd6, 1'b0, 33, i);
    goto(i + 33);
    fl32 = 1'b1; sd32 = 1'b1; a32 = 32'd8; b32 = 32'd2; tg32 = 5'd20;
    wait_cyc(1);
    fl32 = 1'b0; sd32 = 1'b0;
    wait_cyc(2);
    chk("done_flush_idle", 64'(busy32), 64'd0);
    wait_cyc(36);

    // 8-bit build: directed boundaries then random pairs, serial issue
    for (int k = 0; k < 7; k++) begin
      model8(vm[k], va[k], vb[k], er8, ee8);
      issue8(vm[k], va[k], vb[k], 5'(k), 1'b1, er8, ee8, (!vm[k] && vb[k] == 8'd0) ? 1 : 9);
      wait_cyc(11);
    end
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      om = 1'($urandom_range(0, 1));
      model8(om, ra, rb, er8, ee8);
      issue8(om, ra, rb, 5'(k + 8), 1'b1, er8, ee8, (!om && rb == 8'd0) ? 1 : 9);
      wait_cyc(11);
    end

    // reset mid-RUN on the 8-bit build
    issue8(1'b1, 8'd5, 8'd5, 5'd31, 1'b0, 8'd0, 1'b0, 9);
    wait_cyc(3);
    rst8 = 1'b1;
    wait_cyc(1);
    chk("w8_rst_busy", 64'(busy8), 64'd0);
    chk("w8_rst_result_valid", 64'(rv8), 64'd0);
    chk("w8_rst_result", 64'(res8), 64'd0);
    chk("w8_rst_exception", 64'(exc8), 64'd0);
    chk("w8_rst_tag_out", 64'(tago8), 64'd0);
    chk("w8_rst_is_mult", 64'(im8), 64'd0);
    chk("w8_rst_is_div", 64'(id8), 64'd0);
    rst8 = 1'b0;
    wait_cyc(12);

    chk("w32_outstanding", 64'(q32.size()), 64'd0);
    chk("w8_outstanding", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
